// File: rtl/calib_pulse_sequencer_pkg.sv
// Shared calibration package for the calibration-trigger initiator.
// Contents:
//   LAT_W_DEF   - default width of latency counters/results
//   TMO_CYC_DEF - default CAL_GTRG timeout in CLKCMS cycles
//   seq_state_t - sequencer FSM state encoding (legacy 3-bit values)
//   STROBE_INJ / STROBE_PLS - MODE values selecting CCBINJ or CCBPLS
package calib_pulse_sequencer_pkg;

    localparam int unsigned LAT_W_DEF   = 8;
    localparam int unsigned TMO_CYC_DEF = 250;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FIRE = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } seq_state_t;

    localparam logic STROBE_INJ = 1'b0;
    localparam logic STROBE_PLS = 1'b1;

endpackage

// File: rtl/calib_pulse_sequencer_if.sv
// Bus between the JTAG/calibration-trigger side and calib_pulse_sequencer.
// master modport (sequencer):
//   in : START, ABORT, MODE, NPULSE[7:0], SPACING[15:0], CAL_GTRG, CALLCT_1
//   out: CCBINJ, CCBPLS, BUSY, DONE, TMO_ERR, SENT_CNT[7:0], GTRG_CNT[7:0],
//        LCT_CNT[7:0], LAST_GLAT[LAT_W-1:0], LAST_LLAT[LAT_W-1:0]
// slave modport: the same signals with directions reversed.
interface calib_pulse_sequencer_if
    import calib_pulse_sequencer_pkg::*;
#(
    parameter int unsigned LAT_W = LAT_W_DEF
) ();

    logic             START;
    logic             ABORT;
    logic             MODE;
    logic [7:0]       NPULSE;
    logic [15:0]      SPACING;
    logic             CAL_GTRG;
    logic             CALLCT_1;
    logic             CCBINJ;
    logic             CCBPLS;
    logic             BUSY;
    logic             DONE;
    logic             TMO_ERR;
    logic [7:0]       SENT_CNT;
    logic [7:0]       GTRG_CNT;
    logic [7:0]       LCT_CNT;
    logic [LAT_W-1:0] LAST_GLAT;
    logic [LAT_W-1:0] LAST_LLAT;

    modport master (
        input  START, ABORT, MODE, NPULSE, SPACING, CAL_GTRG, CALLCT_1,
        output CCBINJ, CCBPLS, BUSY, DONE, TMO_ERR,
               SENT_CNT, GTRG_CNT, LCT_CNT, LAST_GLAT, LAST_LLAT
    );

    modport slave (
        output START, ABORT, MODE, NPULSE, SPACING, CAL_GTRG, CALLCT_1,
        input  CCBINJ, CCBPLS, BUSY, DONE, TMO_ERR,
               SENT_CNT, GTRG_CNT, LCT_CNT, LAST_GLAT, LAST_LLAT
    );

endinterface

// File: rtl/calib_pulse_sequencer_edge_lat_capture.sv
// Returned-strobe watcher: registers the strobe, detects rising edges, and
// while armed counts the first edge of each shot and captures its latency.
// Ports:
//   CLKCMS, RST - clock, async active-high reset
//   i_sig       - raw returned strobe
//   i_arm       - edges are accepted only while high (sequencer WAIT state)
//   i_clear     - run start: clears count, captured latency and shot flag
//   i_shot      - new shot issued: re-enables first-edge capture
//   i_lat       - shared latency count
//   o_edge      - accepted edge this cycle
//   o_last      - latency of the last accepted edge
//   o_cnt       - number of accepted edges this run
module edge_lat_capture #(
    parameter int unsigned LAT_W = 8
) (
    input  logic             CLKCMS,
    input  logic             RST,
    input  logic             i_sig,
    input  logic             i_arm,
    input  logic             i_clear,
    input  logic             i_shot,
    input  logic [LAT_W-1:0] i_lat,
    output logic             o_edge,
    output logic [LAT_W-1:0] o_last,
    output logic [7:0]       o_cnt
);

    logic             r_cur;
    logic             r_prev;
    logic             r_seen;
    logic [LAT_W-1:0] r_last;
    logic [7:0]       r_cnt;
    logic             w_rise;

    assign w_rise = r_cur & ~r_prev;
    // r_seen blocks later edges of the same shot
    assign o_edge = w_rise & i_arm & ~r_seen;
    assign o_last = r_last;
    assign o_cnt  = r_cnt;

    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
            r_seen <= 1'b0;
            r_last <= '0;
            r_cnt  <= '0;
        end else begin
            r_cur  <= i_sig;
            r_prev <= r_cur;
            if (i_clear) begin
                r_seen <= 1'b0;
                r_last <= '0;
                r_cnt  <= '0;
            end else if (i_shot) begin
                r_seen <= 1'b0;
            end else if (o_edge) begin
                r_seen <= 1'b1;
                r_last <= i_lat;
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/calib_pulse_sequencer.sv
// Calibration-trigger initiator: fires a programmed train of CCBINJ/CCBPLS
// strobes, measures CAL_GTRG / CALLCT_1 return latency and counts returns,
// and flags shots whose CAL_GTRG does not come back within TMO_CYC cycles.
// Ports:
//   CLKCMS - system clock (posedge)
//   RST    - asynchronous active-high reset
//   cal    - calib_pulse_sequencer_if master modport (control, strobes,
//            returned strobes, status and readback counters)
module calib_pulse_sequencer
    import calib_pulse_sequencer_pkg::*;
#(
    parameter int unsigned LAT_W   = LAT_W_DEF,
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input logic                     CLKCMS,
    input logic                     RST,
    calib_pulse_sequencer_if.master cal
);

    localparam logic [LAT_W-1:0] TMO_VAL = LAT_W'(TMO_CYC);

    seq_state_t       r_state;
    seq_state_t       w_state_nx;
    logic             r_start_cur;
    logic             r_start_prev;
    logic [7:0]       r_npulse;
    logic [15:0]      r_spacing;
    logic             r_mode;
    logic [7:0]       r_sent;
    logic [LAT_W-1:0] r_lat;
    logic [15:0]      r_gap;
    logic             r_tmo;
    logic             r_inj;
    logic             r_pls;
    logic             r_busy;
    logic             r_done;

    logic             w_start_edge;
    logic             w_run_clear;
    logic             w_mode_nx;
    logic             w_gtrg_edge;
    logic             w_lct_edge;
    logic             w_tmo;
    logic             w_in_wait;
    logic             w_in_fire;

    assign w_start_edge = r_start_cur & ~r_start_prev;
    assign w_in_wait    = (r_state == ST_WAIT);
    assign w_in_fire    = (r_state == ST_FIRE);
    assign w_run_clear  = (r_state == ST_IDLE) && w_start_edge && !cal.ABORT;
    // MODE is latched in the same cycle the first strobe is registered
    assign w_mode_nx    = w_run_clear ? cal.MODE : r_mode;
    // a GTRG edge in the timeout cycle wins
    assign w_tmo        = w_in_wait && !w_gtrg_edge && (r_lat == TMO_VAL);

    edge_lat_capture #(.LAT_W(LAT_W)) u_gtrg (
        .CLKCMS  (CLKCMS),
        .RST     (RST),
        .i_sig   (cal.CAL_GTRG),
        .i_arm   (w_in_wait),
        .i_clear (w_run_clear),
        .i_shot  (w_in_fire),
        .i_lat   (r_lat),
        .o_edge  (w_gtrg_edge),
        .o_last  (cal.LAST_GLAT),
        .o_cnt   (cal.GTRG_CNT)
    );

    edge_lat_capture #(.LAT_W(LAT_W)) u_lct (
        .CLKCMS  (CLKCMS),
        .RST     (RST),
        .i_sig   (cal.CALLCT_1),
        .i_arm   (w_in_wait),
        .i_clear (w_run_clear),
        .i_shot  (w_in_fire),
        .i_lat   (r_lat),
        .o_edge  (w_lct_edge),
        .o_last  (cal.LAST_LLAT),
        .o_cnt   (cal.LCT_CNT)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_start_edge) w_state_nx = (cal.NPULSE == '0) ? ST_FIN : ST_FIRE;
            ST_FIRE: w_state_nx = ST_WAIT;
            ST_WAIT: if (w_gtrg_edge || w_tmo) w_state_nx = ST_GAP;
            // GAP lasts SPACING+1 cycles
            ST_GAP:  if (r_gap == r_spacing) w_state_nx = (r_sent == r_npulse) ? ST_FIN : ST_FIRE;
            ST_FIN:  w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
        if (cal.ABORT) w_state_nx = ST_IDLE;
    end

    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_start_cur  <= 1'b0;
            r_start_prev <= 1'b0;
            r_npulse     <= '0;
            r_spacing    <= '0;
            r_mode       <= 1'b0;
            r_sent       <= '0;
            r_lat        <= '0;
            r_gap        <= '0;
            r_tmo        <= 1'b0;
            r_inj        <= 1'b0;
            r_pls        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_start_cur  <= cal.START;
            r_start_prev <= r_start_cur;
            if (w_run_clear) begin
                r_npulse  <= cal.NPULSE;
                r_spacing <= cal.SPACING;
                r_mode    <= cal.MODE;
            end
            // outputs decoded from next state so they align with the state register
            r_inj  <= (w_state_nx == ST_FIRE) && (w_mode_nx == STROBE_INJ);
            r_pls  <= (w_state_nx == ST_FIRE) && (w_mode_nx == STROBE_PLS);
            r_busy <= (w_state_nx == ST_FIRE) || (w_state_nx == ST_WAIT) || (w_state_nx == ST_GAP);
            r_done <= (w_state_nx == ST_FIN);
            if (w_run_clear)    r_sent <= '0;
            else if (w_in_fire) r_sent <= r_sent + 8'd1;
            if (w_run_clear) r_tmo <= 1'b0;
            else if (w_tmo)  r_tmo <= 1'b1;
            if (w_in_fire)                     r_lat <= LAT_W'(1);
            else if (w_in_wait && r_lat != '1) r_lat <= r_lat + LAT_W'(1);
            if (r_state == ST_GAP) r_gap <= r_gap + 16'd1;
            else                   r_gap <= '0;
        end
    end

    assign cal.CCBINJ   = r_inj;
    assign cal.CCBPLS   = r_pls;
    assign cal.BUSY     = r_busy;
    assign cal.DONE     = r_done;
    assign cal.TMO_ERR  = r_tmo;
    assign cal.SENT_CNT = r_sent;

endmodule

// File: tb/tb_calib_pulse_sequencer.sv
// Directed testbench for calib_pulse_sequencer. A trigger-logic model returns
// CAL_GTRG / CALLCT_1 so that the registered edge is detected glat / llat
// cycles after the strobe cycle (raw level rises one cycle earlier, since the
// DUT input register is part of the measured latency).
module tb_calib_pulse_sequencer;

    logic CLKCMS = 1'b0;
    logic RST    = 1'b1;
    always #5 CLKCMS = ~CLKCMS;

    calib_pulse_sequencer_if #(.LAT_W(8)) bus ();

    calib_pulse_sequencer #(.LAT_W(8), .TMO_CYC(250)) dut (
        .CLKCMS (CLKCMS),
        .RST    (RST),
        .cal    (bus)
    );

    int checks = 0;
    int errors = 0;

    // cycle numbering: cycle n lies between posedge n and posedge n+1
    int cyc = 0;
    always @(posedge CLKCMS) cyc <= cyc + 1;

    int strobe_t[$];
    int inj_total  = 0;
    int pls_total  = 0;
    int done_total = 0;
    int busy_total = 0;
    int done_t     = 0;

    always @(negedge CLKCMS) begin
        if (bus.CCBINJ) begin inj_total++; strobe_t.push_back(cyc); end
        if (bus.CCBPLS) begin pls_total++; strobe_t.push_back(cyc); end
        if (bus.DONE)   begin done_total++; done_t = cyc; end
        if (bus.BUSY)   busy_total++;
    end

    // trigger-logic model
    bit   resp_en = 1'b0;
    int   glat    = 122;
    int   llat    = 20;
    int   age     = 0;
    bit   armed   = 1'b0;
    logic m_g     = 1'b0;
    logic m_l     = 1'b0;
    logic stray_g = 1'b0;

    always @(negedge CLKCMS) begin
        if (bus.CCBINJ || bus.CCBPLS) begin armed = 1'b1; age = 0; end
        else if (armed) age = age + 1;
        m_g = resp_en && armed && (age >= glat - 1) && (age <= glat + 2);
        m_l = resp_en && armed && (age >= llat - 1) && (age <= llat + 2);
    end

    assign bus.CAL_GTRG = m_g | stray_g;
    assign bus.CALLCT_1 = m_l;

    task automatic pulse_start(output int c);
        @(negedge CLKCMS);
        bus.START = 1'b1;
        c = cyc;
        @(negedge CLKCMS);
        @(negedge CLKCMS);
        bus.START = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLKCMS);
            if (done_total > d0) begin ok = 1'b1; break; end
        end
        repeat (5) @(negedge CLKCMS);
    endtask

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLKCMS);
            if (strobe_t.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLKCMS);
        checks++; if ({bus.CCBINJ, bus.CCBPLS, bus.BUSY, bus.DONE, bus.TMO_ERR} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b, expected 00000", {bus.CCBINJ, bus.CCBPLS, bus.BUSY, bus.DONE, bus.TMO_ERR}); end
        checks++; if ({bus.SENT_CNT, bus.GTRG_CNT, bus.LCT_CNT} !== 24'h0) begin errors++; $display("FAIL reset_counts: got %h, expected 000000", {bus.SENT_CNT, bus.GTRG_CNT, bus.LCT_CNT}); end
        checks++; if ({bus.LAST_GLAT, bus.LAST_LLAT} !== 16'h0) begin errors++; $display("FAIL reset_last: got %h, expected 0000", {bus.LAST_GLAT, bus.LAST_LLAT}); end
        @(negedge CLKCMS); RST = 1'b0;
        repeat (5) @(negedge CLKCMS);
        checks++; if (busy_total !== 0) begin errors++; $display("FAIL reset_idle_busy: got %0d busy cycles, expected 0", busy_total); end
    endtask

    task automatic test_inject_train;
        int s0, d0, i0, p0, c; bit ok;
        bus.MODE = 1'b0; bus.NPULSE = 8'd3; bus.SPACING = 16'd10;
        glat = 122; llat = 20; resp_en = 1'b1;
        s0 = strobe_t.size(); d0 = done_total; i0 = inj_total; p0 = pls_total;
        pulse_start(c);
        wait_done(d0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL train_done_wait: got no DONE in 1000 cycles, expected DONE"); end
        checks++; if (inj_total - i0 !== 3) begin errors++; $display("FAIL train_inj_count: got %0d, expected 3", inj_total - i0); end
        checks++; if (pls_total - p0 !== 0) begin errors++; $display("FAIL train_pls_count: got %0d, expected 0", pls_total - p0); end
        if (strobe_t.size() >= s0 + 3) begin
            checks++; if (strobe_t[s0] - c !== 2) begin errors++; $display("FAIL train_first_strobe: got %0d, expected 2", strobe_t[s0] - c); end
            checks++; if (strobe_t[s0+1] - strobe_t[s0] !== 134) begin errors++; $display("FAIL train_period1: got %0d, expected 134", strobe_t[s0+1] - strobe_t[s0]); end
            checks++; if (strobe_t[s0+2] - strobe_t[s0+1] !== 134) begin errors++; $display("FAIL train_period2: got %0d, expected 134", strobe_t[s0+2] - strobe_t[s0+1]); end
            checks++; if (done_t - strobe_t[s0+2] !== 134) begin errors++; $display("FAIL train_done_time: got %0d, expected 134", done_t - strobe_t[s0+2]); end
        end
        checks++; if (bus.SENT_CNT !== 8'd3) begin errors++; $display("FAIL train_sent: got %0d, expected 3", bus.SENT_CNT); end
        checks++; if (bus.GTRG_CNT !== 8'd3) begin errors++; $display("FAIL train_gtrg_cnt: got %0d, expected 3", bus.GTRG_CNT); end
        checks++; if (bus.LCT_CNT !== 8'd3) begin errors++; $display("FAIL train_lct_cnt: got %0d, expected 3", bus.LCT_CNT); end
        checks++; if (bus.LAST_GLAT !== 8'd122) begin errors++; $display("FAIL train_glat: got %0d, expected 122", bus.LAST_GLAT); end
        checks++; if (bus.LAST_LLAT !== 8'd20) begin errors++; $display("FAIL train_llat: got %0d, expected 20", bus.LAST_LLAT); end
        checks++; if (bus.TMO_ERR !== 1'b0) begin errors++; $display("FAIL train_tmo: got %b, expected 0", bus.TMO_ERR); end
        checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL train_done_count: got %0d, expected 1", done_total - d0); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL train_busy_end: got %b, expected 0", bus.BUSY); end
    endtask

    task automatic test_pulse_timeout;
        int s0, d0, i0, p0, c; bit ok;
        bus.MODE = 1'b1; bus.NPULSE = 8'd1; bus.SPACING = 16'd10; resp_en = 1'b0;
        s0 = strobe_t.size(); d0 = done_total; i0 = inj_total; p0 = pls_total;
        pulse_start(c);
        wait_done(d0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_done_wait: got no DONE in 1000 cycles, expected DONE"); end
        checks++; if (pls_total - p0 !== 1) begin errors++; $display("FAIL tmo_pls_count: got %0d, expected 1", pls_total - p0); end
        checks++; if (inj_total - i0 !== 0) begin errors++; $display("FAIL tmo_inj_count: got %0d, expected 0", inj_total - i0); end
        if (strobe_t.size() >= s0 + 1) begin
            checks++; if (done_t - strobe_t[s0] !== 262) begin errors++; $display("FAIL tmo_done_time: got %0d, expected 262", done_t - strobe_t[s0]); end
        end
        checks++; if (bus.TMO_ERR !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b, expected 1", bus.TMO_ERR); end
        checks++; if (bus.GTRG_CNT !== 8'd0) begin errors++; $display("FAIL tmo_gtrg_cnt: got %0d, expected 0", bus.GTRG_CNT); end
        checks++; if (bus.LAST_GLAT !== 8'd0) begin errors++; $display("FAIL tmo_glat_cleared: got %0d, expected 0", bus.LAST_GLAT); end
        checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL tmo_done_count: got %0d, expected 1", done_total - d0); end
    endtask

    task automatic test_zero_pulses;
        int s0, d0, b0, c; bit ok;
        bus.MODE = 1'b0; bus.NPULSE = 8'd0;
        s0 = strobe_t.size(); d0 = done_total; b0 = busy_total;
        pulse_start(c);
        wait_done(d0, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_done_wait: got no DONE in 50 cycles, expected DONE"); end
        checks++; if (done_t - c !== 2) begin errors++; $display("FAIL zero_done_time: got %0d, expected 2", done_t - c); end
        checks++; if (strobe_t.size() - s0 !== 0) begin errors++; $display("FAIL zero_strobes: got %0d, expected 0", strobe_t.size() - s0); end
        checks++; if (busy_total - b0 !== 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles, expected 0", busy_total - b0); end
        checks++; if (bus.TMO_ERR !== 1'b0) begin errors++; $display("FAIL zero_tmo_cleared: got %b, expected 0", bus.TMO_ERR); end
    endtask

    task automatic test_abort;
        int s0, d0, c; bit ok;
        bus.MODE = 1'b0; bus.NPULSE = 8'd5; bus.SPACING = 16'd10;
        glat = 40; llat = 20; resp_en = 1'b1;
        s0 = strobe_t.size(); d0 = done_total;
        pulse_start(c);
        wait_strobes(s0 + 2, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_second_strobe: got none in 300 cycles, expected strobe"); end
        repeat (10) @(negedge CLKCMS);
        bus.ABORT = 1'b1;
        @(negedge CLKCMS);
        bus.ABORT = 1'b0;
        repeat (300) @(negedge CLKCMS);
        checks++; if (done_total - d0 !== 0) begin errors++; $display("FAIL abort_no_done: got %0d, expected 0", done_total - d0); end
        checks++; if (strobe_t.size() - s0 !== 2) begin errors++; $display("FAIL abort_strobes: got %0d, expected 2", strobe_t.size() - s0); end
        checks++; if (bus.SENT_CNT !== 8'd2) begin errors++; $display("FAIL abort_sent: got %0d, expected 2", bus.SENT_CNT); end
        checks++; if ({bus.GTRG_CNT, bus.LCT_CNT} !== {8'd1, 8'd1}) begin errors++; $display("FAIL abort_counts: got %0d/%0d, expected 1/1", bus.GTRG_CNT, bus.LCT_CNT); end
        checks++; if ({bus.LAST_GLAT, bus.LAST_LLAT} !== {8'd40, 8'd20}) begin errors++; $display("FAIL abort_last: got %0d/%0d, expected 40/20", bus.LAST_GLAT, bus.LAST_LLAT); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b, expected 0", bus.BUSY); end
        bus.NPULSE = 8'd1;
        d0 = done_total;
        pulse_start(c);
        checks++; if ({bus.SENT_CNT, bus.GTRG_CNT, bus.LCT_CNT, bus.LAST_GLAT, bus.LAST_LLAT} !== 40'h0) begin errors++; $display("FAIL restart_cleared: got %h, expected 0000000000", {bus.SENT_CNT, bus.GTRG_CNT, bus.LCT_CNT, bus.LAST_GLAT, bus.LAST_LLAT}); end
        wait_done(d0, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL restart_done_wait: got no DONE in 300 cycles, expected DONE"); end
        checks++; if ({bus.SENT_CNT, bus.GTRG_CNT} !== {8'd1, 8'd1}) begin errors++; $display("FAIL restart_counts: got %0d/%0d, expected 1/1", bus.SENT_CNT, bus.GTRG_CNT); end
    endtask

    task automatic test_back_to_back;
        int s0, d0, c; bit ok;
        bus.MODE = 1'b0; bus.NPULSE = 8'd2; bus.SPACING = 16'd30;
        glat = 30; llat = 20; resp_en = 1'b1;
        s0 = strobe_t.size(); d0 = done_total;
        pulse_start(c);
        wait_strobes(s0 + 1, 50, ok);
        repeat (40) @(negedge CLKCMS);
        // stray GTRG and a second START, both inside the first GAP
        stray_g = 1'b1; bus.START = 1'b1;
        repeat (2) @(negedge CLKCMS);
        stray_g = 1'b0; bus.START = 1'b0;
        wait_done(d0, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stray_done_wait: got no DONE in 500 cycles, expected DONE"); end
        checks++; if (strobe_t.size() - s0 !== 2) begin errors++; $display("FAIL stray_strobes: got %0d, expected 2", strobe_t.size() - s0); end
        if (strobe_t.size() >= s0 + 2) begin
            checks++; if (strobe_t[s0+1] - strobe_t[s0] !== 62) begin errors++; $display("FAIL stray_period: got %0d, expected 62", strobe_t[s0+1] - strobe_t[s0]); end
            checks++; if (done_t - strobe_t[s0+1] !== 62) begin errors++; $display("FAIL stray_done_time: got %0d, expected 62", done_t - strobe_t[s0+1]); end
        end
        checks++; if ({bus.GTRG_CNT, bus.LCT_CNT} !== {8'd2, 8'd2}) begin errors++; $display("FAIL stray_counts: got %0d/%0d, expected 2/2", bus.GTRG_CNT, bus.LCT_CNT); end
        checks++; if (bus.LAST_GLAT !== 8'd30) begin errors++; $display("FAIL stray_glat: got %0d, expected 30", bus.LAST_GLAT); end
        checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL stray_done_count: got %0d, expected 1", done_total - d0); end
    endtask

    task automatic test_timeout_boundary;
        int s0, d0, c; bit ok;
        bus.MODE = 1'b0; bus.NPULSE = 8'd1; bus.SPACING = 16'd10;
        glat = 250; resp_en = 1'b1;
        s0 = strobe_t.size(); d0 = done_total;
        pulse_start(c);
        wait_done(d0, 600, ok);
        checks++; if ({bus.GTRG_CNT, 7'b0, bus.TMO_ERR} !== {8'd1, 8'd0}) begin errors++; $display("FAIL edge_at_tmo: got gtrg %0d tmo %b, expected gtrg 1 tmo 0", bus.GTRG_CNT, bus.TMO_ERR); end
        checks++; if (bus.LAST_GLAT !== 8'd250) begin errors++; $display("FAIL edge_at_tmo_glat: got %0d, expected 250", bus.LAST_GLAT); end
        if (strobe_t.size() >= s0 + 1) begin
            checks++; if (done_t - strobe_t[s0] !== 262) begin errors++; $display("FAIL edge_at_tmo_done: got %0d, expected 262", done_t - strobe_t[s0]); end
        end
        glat = 251; d0 = done_total;
        pulse_start(c);
        wait_done(d0, 600, ok);
        checks++; if ({bus.GTRG_CNT, 7'b0, bus.TMO_ERR} !== {8'd0, 8'd1}) begin errors++; $display("FAIL edge_after_tmo: got gtrg %0d tmo %b, expected gtrg 0 tmo 1", bus.GTRG_CNT, bus.TMO_ERR); end
    endtask

    task automatic test_reset_mid_wait;
        int s0, d0, c; bit ok;
        bus.MODE = 1'b0; bus.NPULSE = 8'd2; bus.SPACING = 16'd10;
        glat = 100; llat = 10; resp_en = 1'b1;
        s0 = strobe_t.size(); d0 = done_total;
        pulse_start(c);
        wait_strobes(s0 + 1, 50, ok);
        repeat (20) @(negedge CLKCMS);
        checks++; if ({bus.BUSY, bus.SENT_CNT, bus.LCT_CNT, bus.LAST_LLAT} !== {1'b1, 8'd1, 8'd1, 8'd10}) begin errors++; $display("FAIL midwait_pre: got busy %b sent %0d lct %0d llat %0d, expected 1 1 1 10", bus.BUSY, bus.SENT_CNT, bus.LCT_CNT, bus.LAST_LLAT); end
        RST = 1'b1;
        #1;
        checks++; if ({bus.CCBINJ, bus.CCBPLS, bus.BUSY, bus.DONE, bus.TMO_ERR} !== 5'b0) begin errors++; $display("FAIL midwait_rst_flags: got %b, expected 00000", {bus.CCBINJ, bus.CCBPLS, bus.BUSY, bus.DONE, bus.TMO_ERR}); end
        checks++; if ({bus.SENT_CNT, bus.GTRG_CNT, bus.LCT_CNT, bus.LAST_GLAT, bus.LAST_LLAT} !== 40'h0) begin errors++; $display("FAIL midwait_rst_regs: got %h, expected 0000000000", {bus.SENT_CNT, bus.GTRG_CNT, bus.LCT_CNT, bus.LAST_GLAT, bus.LAST_LLAT}); end
        @(negedge CLKCMS);
        RST = 1'b0;
        repeat (150) @(negedge CLKCMS);
        checks++; if (strobe_t.size() - s0 !== 1) begin errors++; $display("FAIL midwait_no_resume: got %0d strobes, expected 1", strobe_t.size() - s0); end
        checks++; if ({bus.BUSY, bus.GTRG_CNT} !== 9'h0 || done_total != d0) begin errors++; $display("FAIL midwait_idle: got busy %b gtrg %0d dones %0d, expected 0 0 0", bus.BUSY, bus.GTRG_CNT, done_total - d0); end
    endtask

    initial begin
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.MODE = 1'b0;
        bus.NPULSE = 8'd0; bus.SPACING = 16'd0;
        test_reset;
        test_inject_train;
        test_pulse_timeout;
        test_zero_pulses;
        test_abort;
        test_back_to_back;
        test_timeout_boundary;
        test_reset_mid_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
